data_mem_responder: RTL and testbench

Memory-side responder for the processor's MEM-stage data interface: accepts one load/store request at a time and services it after a fixed number of wait states. It translates byte addresses by removing the data-segment base and dividing by 4, rejects misaligned or out-of-range accesses, and returns a one-cycle response pulse. While a request is outstanding, it drives a stall toward the hazard logic.

---
 rtl/mem_resp_pkg.sv | 13 +
 rtl/data_mem_addr_decode.sv | 28 ++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
  localparam logic [7:0]  ERR_CNT_MAX       = 8'd255;

endpackage

// File: rtl/data_mem_addr_decode.sv
// Byte address to word index translation for the data segment, with
// alignment and range classification. Purely combinational.
module data_mem_addr_decode
  import mem_resp_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic [31:0]                     addr_i,
  output logic [$clog2(MEMORY_DEPTH)-1:0] index_o,
  output logic                            misaligned_o,
  output logic                            out_of_range_o
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);

  logic [31:0] off;

  // Offset from the segment base; comparing the byte offset against
  // depth*4 is the same as comparing off[31:2] against the depth.
  always_comb begin
    off            = addr_i - BASE_ADDR;
    index_o        = off[IDX_W+1:2];
    misaligned_o   = (addr_i[1:0] != 2'b00);
    out_of_range_o = (addr_i < BASE_ADDR) || (off >= (32'(MEMORY_DEPTH) << 2));
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the MEM-stage data port: one request at a time,
// fixed wait states, single-cycle response pulse and a stall toward hazards.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  ready_o,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  stall_o,
  output logic [7:0]            err_count_o
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    resp_err_q, resp_err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem_q [MEMORY_DEPTH];

  logic [IDX_W-1:0]        dec_index;
  logic                    dec_misaligned;
  logic                    dec_out_of_range;

  data_mem_addr_decode #(
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .BASE_ADDR    (BASE_ADDR)
  ) u_decode (
    .addr_i         (req_addr_i),
    .index_o        (dec_index),
    .misaligned_o   (dec_misaligned),
    .out_of_range_o (dec_out_of_range)
  );

  assign ready_o      = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = resp_err_q;
  assign err_count_o  = err_cnt_q;
  assign stall_o      = req_valid_i & ~resp_valid_o;

  // Next-state logic: accept in IDLE, count down in WAIT, access on cnt==0,
  // hold the response for one RESP cycle and then clear it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    index_d    = index_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    err_cnt_d  = err_cnt_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_STATES);
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          index_d = dec_index;
          err_d   = dec_misaligned | dec_out_of_range;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = 4'(cnt_q - 4'd1);
        end else begin
          state_d = RESP;
          if (err_q) begin
            rdata_d    = '0;
            resp_err_d = 1'b1;
          end else if (write_q) begin
            rdata_d = '0;
            mem_we  = 1'b1;
          end else begin
            rdata_d = mem_q[index_q];
          end
        end
      end
      RESP: begin
        state_d    = IDLE;
        rdata_d    = '0;
        resp_err_d = 1'b0;
        if (resp_err_q && (err_cnt_q != ERR_CNT_MAX)) begin
          err_cnt_d = 8'(err_cnt_q + 8'd1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      index_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      index_q    <= index_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage array: not reset, and a store is dropped if reset coincides.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[index_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a behavioural model.
module tb_data_mem_responder;

  localparam int          WS    = 2;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        ready;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;
  logic        stall;
  logic [7:0]  errCount;

  int assertCount = 0;
  int failCount   = 0;
  int errModel    = 0;
  logic [31:0] memModel [int];

  data_mem_responder #(
    .DATA_WIDTH   (32),
    .MEMORY_DEPTH (DEPTH),
    .WAIT_STATES  (WS),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (reqValid),
    .req_write_i  (reqWrite),
    .req_addr_i   (reqAddr),
    .req_wdata_i  (reqWdata),
    .ready_o      (ready),
    .resp_valid_o (respValid),
    .resp_rdata_o (respRdata),
    .resp_err_o   (respErr),
    .stall_o      (stall),
    .err_count_o  (errCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit isErr(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (a < BASE) || (off / 4 >= DEPTH);
  endfunction

  // One complete transaction; starts and ends just after a falling edge.
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d);
    bit e;
    int idx;
    bit known;
    logic [31:0] expData;
    e   = isErr(a);
    idx = int'((a - BASE) / 4);
    known = 1'b1;
    expData = 32'h0;
    if (!e && !w) begin
      if (memModel.exists(idx)) expData = memModel[idx];
      else known = 1'b0;
    end
    reqValid = 1'b1;
    reqWrite = w;
    reqAddr  = a;
    reqWdata = d;
    #1;
    checkOutput("ready_idle", ready, 1);
    checkOutput("stall_req", stall, 1);
    @(posedge clk);
    #1;
    reqAddr  = $urandom;
    reqWdata = $urandom;
    reqWrite = ~w;
    for (int k = 1; k <= WS + 1; k++) begin
      @(negedge clk);
      checkOutput("resp_early", respValid, 0);
      checkOutput("ready_busy", ready, 0);
      checkOutput("stall_wait", stall, 1);
    end
    @(negedge clk);
    checkOutput("resp_pulse", respValid, 1);
    checkOutput("stall_resp", stall, 0);
    checkOutput("resp_err", respErr, 32'(e));
    if (known) checkOutput("resp_rdata", respRdata, expData);
    reqValid = 1'b0;
    if (!e && w) memModel[idx] = d;
    if (e && errModel < 255) errModel++;
    @(negedge clk);
    checkOutput("ready_back", ready, 1);
    checkOutput("resp_clear", respValid, 0);
    checkOutput("rdata_clear", respRdata, 0);
    checkOutput("err_clear", respErr, 0);
    checkOutput("err_count", errCount, 32'(errModel));
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    reset    = 1'b1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = 32'h0;
    reqWdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_resp", respValid, 0);
    checkOutput("rst_rdata", respRdata, 0);
    checkOutput("rst_err", respErr, 0);
    checkOutput("rst_errcnt", errCount, 0);
    checkOutput("rst_stall", stall, 0);
    @(negedge clk);

    // Store then load, misaligned access, range edges.
    applyStimulus(1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h1001_0008, 32'h0);
    applyStimulus(1'b0, 32'h1001_0002, 32'h0);
    applyStimulus(1'b1, 32'h1001_000A, 32'h0BAD_0BAD);
    applyStimulus(1'b0, 32'h1001_0008, 32'h0);
    applyStimulus(1'b1, 32'h1001_03FC, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h1001_03FC, 32'h0);
    applyStimulus(1'b0, 32'h1001_0400, 32'h0);
    applyStimulus(1'b0, 32'h1000_FFFC, 32'h0);

    // Reset while a store sits in the wait state with one count left.
    applyStimulus(1'b1, 32'h1001_0010, 32'hAAAA_5555);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddr  = 32'h1001_0010;
    reqWdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    errModel = 0;
    #1;
    checkOutput("midrst_ready", ready, 1);
    checkOutput("midrst_resp", respValid, 0);
    checkOutput("midrst_rdata", respRdata, 0);
    checkOutput("midrst_errcnt", errCount, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("midrst_nopulse", respValid, 0);
    end
    applyStimulus(1'b0, 32'h1001_0010, 32'h0);

    // Random mix of valid, misaligned and out-of-range accesses.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    a = BASE + 32'(4 * $urandom_range(0, 15));
        2:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        default: a = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 8))
                                                 : BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
    end

    // Back-to-back loads with the request held: one response per WS+3 cycles.
    applyStimulus(1'b1, 32'h1001_0008, 32'h5A5A_A5A5);
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqAddr  = 32'h1001_0008;
    for (int j = 1; j <= 3 * (WS + 3); j++) begin
      @(negedge clk);
      checkOutput("b2b_resp", respValid, 32'(j % (WS + 3) == WS + 2));
      checkOutput("b2b_rdata", respRdata, (j % (WS + 3) == WS + 2) ? memModel[2] : 32'h0);
      checkOutput("b2b_ready", ready, 32'(j % (WS + 3) == 0));
      checkOutput("b2b_stall", stall, 32'(j % (WS + 3) != WS + 2));
    end
    reqValid = 1'b0;
    @(negedge clk);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 32'h1001_0001, 32'h0);
    end
    checkOutput("err_saturated", errCount, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
